// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared constants for the MEM/WB skid register: FSM encodings, default
// widths and stall counter sizing.
package mem_wb_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;

  // Occupancy states of the two-entry buffer
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  localparam int                     STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// Handshake + payload bundle between the MEM stage and the WB stage.
// The slave modport is the skid register's view; master is the producer/consumer view.
interface mem_wb_skid_reg_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic [REG_ADDR_W-1:0] in_write_reg;
  logic [DATA_W-1:0]     in_mem_data;
  logic [DATA_W-1:0]     in_alu_result;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_reg_write;
  logic                  out_mem_to_reg;
  logic [REG_ADDR_W-1:0] out_write_reg;
  logic [DATA_W-1:0]     out_mem_data;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_wb_data;

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_write_reg, in_mem_data,
           in_alu_result, out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_write_reg,
           out_mem_data, out_alu_result, out_wb_data
  );

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_write_reg, in_mem_data,
           in_alu_result, out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_write_reg,
           out_mem_data, out_alu_result, out_wb_data
  );

endinterface

// File: rtl/mem_wb_skid_reg_pipe_entry_reg.sv
// One MEM/WB payload slot with load enable. The writeback value is selected
// when the slot is loaded so the WB stage sees a registered, mux-free value.
module pipe_entry_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  reg_write_d,
  input  logic                  mem_to_reg_d,
  input  logic [REG_ADDR_W-1:0] write_reg_d,
  input  logic [DATA_W-1:0]     mem_data_d,
  input  logic [DATA_W-1:0]     alu_result_d,
  output logic                  reg_write_q,
  output logic                  mem_to_reg_q,
  output logic [REG_ADDR_W-1:0] write_reg_q,
  output logic [DATA_W-1:0]     mem_data_q,
  output logic [DATA_W-1:0]     alu_result_q,
  output logic [DATA_W-1:0]     wb_data_q
);

  // Capture the payload and its writeback select on the falling edge when loaded
  always_ff @(negedge clk) begin
    // NOTE: payload is reset as well as control, because every output of the
    // block must read zero after reset, not just the valid flag.
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_reg_q  <= '0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      wb_data_q    <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      wb_data_q    <= mem_to_reg_d ? mem_data_d : alu_result_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with valid/ready handshake and a two-entry skid
// buffer. Optional stall counter enabled by defining MEM_WB_STALL_CNT_EN.
// All state changes on the falling edge of clk; rst is synchronous active-high.
module mem_wb_skid_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  mem_wb_skid_reg_if.slave       bus
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       drain;
  logic       main_load;
  logic       main_from_skid;
  logic       skid_load;

  logic                  main_reg_write;
  logic                  main_mem_to_reg;
  logic [REG_ADDR_W-1:0] main_write_reg;
  logic [DATA_W-1:0]     main_mem_data;
  logic [DATA_W-1:0]     main_alu_result;
  logic [DATA_W-1:0]     main_wb_data;

  logic                  skid_reg_write;
  logic                  skid_mem_to_reg;
  logic [REG_ADDR_W-1:0] skid_write_reg;
  logic [DATA_W-1:0]     skid_mem_data;
  logic [DATA_W-1:0]     skid_alu_result;
  logic [DATA_W-1:0]     skid_wb_data;

  // The main slot recomputes wb_data from the skid's raw fields on transfer,
  // so the skid's own copy has no reader.
  logic unused_skid_wb;
  assign unused_skid_wb = ^skid_wb_data;

  // Handshake flags depend only on the state register
  assign bus.in_ready  = (state != ST_FULL);
  assign bus.out_valid = (state != ST_EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign drain         = bus.out_valid & bus.out_ready;

  // Next-state and slot-load decode; flush overrides any handshake
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state_nxt = ST_ONE;
          main_load = 1'b1;
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_nxt = ST_FULL;
            skid_load = 1'b1;
          end else if (drain) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: if (drain) begin
          state_nxt      = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(negedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_main (
    .clk          (clk),
    .rst          (rst),
    .load         (main_load),
    .reg_write_d  (main_from_skid ? skid_reg_write  : bus.in_reg_write),
    .mem_to_reg_d (main_from_skid ? skid_mem_to_reg : bus.in_mem_to_reg),
    .write_reg_d  (main_from_skid ? skid_write_reg  : bus.in_write_reg),
    .mem_data_d   (main_from_skid ? skid_mem_data   : bus.in_mem_data),
    .alu_result_d (main_from_skid ? skid_alu_result : bus.in_alu_result),
    .reg_write_q  (main_reg_write),
    .mem_to_reg_q (main_mem_to_reg),
    .write_reg_q  (main_write_reg),
    .mem_data_q   (main_mem_data),
    .alu_result_q (main_alu_result),
    .wb_data_q    (main_wb_data)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .reg_write_d  (bus.in_reg_write),
    .mem_to_reg_d (bus.in_mem_to_reg),
    .write_reg_d  (bus.in_write_reg),
    .mem_data_d   (bus.in_mem_data),
    .alu_result_d (bus.in_alu_result),
    .reg_write_q  (skid_reg_write),
    .mem_to_reg_q (skid_mem_to_reg),
    .write_reg_q  (skid_write_reg),
    .mem_data_q   (skid_mem_data),
    .alu_result_q (skid_alu_result),
    .wb_data_q    (skid_wb_data)
  );

  // reg_write is masked so a stale payload never triggers a register-file write
  assign bus.out_reg_write  = main_reg_write & bus.out_valid;
  assign bus.out_mem_to_reg = main_mem_to_reg;
  assign bus.out_write_reg  = main_write_reg;
  assign bus.out_mem_data   = main_mem_data;
  assign bus.out_alu_result = main_alu_result;
  assign bus.out_wb_data    = main_wb_data;

`ifdef MEM_WB_STALL_CNT_EN
  // Saturating count of cycles where WB holds off a valid entry; flush keeps it
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && stall_cnt != STALL_CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: a queue-based reference model
// checked every cycle, plus directed literal checks.
module tb_mem_wb_skid_reg;

  typedef struct {
    bit          rw;
    bit          m2r;
    logic [2:0]  wr;
    logic [15:0] md;
    logic [15:0] alu;
  } entry_t;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;
  bit   chk_en;

  mem_wb_skid_reg_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

`ifdef MEM_WB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  mem_wb_skid_reg #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_cnt(stall_cnt));
`else
  mem_wb_skid_reg #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two accepted entries
  entry_t      mq[$];
  int          m_cnt;
  bit          m_acc;
  bit          m_drn;
  entry_t      m_new;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (mq.size() > 0 && !bus.out_ready && m_cnt < 65535) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        m_acc = bus.in_valid && (mq.size() < 2);
        m_drn = (mq.size() > 0) && bus.out_ready;
        m_new.rw  = bus.in_reg_write;
        m_new.m2r = bus.in_mem_to_reg;
        m_new.wr  = bus.in_write_reg;
        m_new.md  = bus.in_mem_data;
        m_new.alu = bus.in_alu_result;
        if (m_drn) void'(mq.pop_front());
        if (m_acc) mq.push_back(m_new);
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle on the rising edge
  always @(posedge clk) begin
    if (chk_en) begin
      check("m_out_valid", bus.out_valid, mq.size() > 0);
      check("m_in_ready", bus.in_ready, mq.size() < 2);
      if (mq.size() > 0) begin
        check("m_reg_write", bus.out_reg_write, mq[0].rw);
        check("m_mem_to_reg", bus.out_mem_to_reg, mq[0].m2r);
        check("m_write_reg", bus.out_write_reg, mq[0].wr);
        check("m_mem_data", bus.out_mem_data, mq[0].md);
        check("m_alu", bus.out_alu_result, mq[0].alu);
        check("m_wb_data", bus.out_wb_data, mq[0].m2r ? mq[0].md : mq[0].alu);
      end else begin
        check("m_reg_write_idle", bus.out_reg_write, 1'b0);
      end
`ifdef MEM_WB_STALL_CNT_EN
      check("m_stall_cnt", stall_cnt, m_cnt);
`endif
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input logic [2:0] wr,
                       input logic [15:0] md, input logic [15:0] alu);
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_to_reg = m2r;
    bus.in_write_reg  = wr;
    bus.in_mem_data   = md;
    bus.in_alu_result = alu;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_reg_write"}, bus.out_reg_write, 1'b0);
    check({tag, "_mem_to_reg"}, bus.out_mem_to_reg, 1'b0);
    check({tag, "_write_reg"}, bus.out_write_reg, 3'd0);
    check({tag, "_mem_data"}, bus.out_mem_data, 16'h0);
    check({tag, "_alu"}, bus.out_alu_result, 16'h0);
    check({tag, "_wb_data"}, bus.out_wb_data, 16'h0);
`ifdef MEM_WB_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 16'h0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);

    // Reset for two cycles
    cycle();
    cycle();
    check_zero_outputs("reset");
    chk_en = 1'b1;

    // First transaction: memory-data writeback, 1-cycle latency
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h1234);
    cycle();
    check("first_out_valid", bus.out_valid, 1'b1);
    check("first_write_reg", bus.out_write_reg, 3'd5);
    check("first_wb_data", bus.out_wb_data, 16'hBEEF);
    check("first_reg_write", bus.out_reg_write, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    check("first_drained", bus.out_valid, 1'b0);

    // Streaming: eight back-to-back ALU results
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'(i), 16'hF000, 16'(i));
      cycle();
      check("stream_wb_data", bus.out_wb_data, 16'(i));
      check("stream_in_ready", bus.in_ready, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cycle();

    // Stall/skid: A and B fill the buffer, C held off until room appears
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h0, 16'h00AA);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 3'd2, 16'h0, 16'h00BB);
    cycle();
    check("skid_full_in_ready", bus.in_ready, 1'b0);
    check("skid_full_wb", bus.out_wb_data, 16'h00AA);
    drive(1'b1, 1'b1, 1'b0, 3'd3, 16'h0, 16'h00CC);
    cycle();
    check("skid_c_held_wb", bus.out_wb_data, 16'h00AA);
    bus.out_ready = 1'b1;
    cycle();
    check("skid_b_wb", bus.out_wb_data, 16'h00BB);
    cycle();
    check("skid_c_wb", bus.out_wb_data, 16'h00CC);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    check("skid_empty", bus.out_valid, 1'b0);

    // Flush priority over accept and drain while full
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h0D0D, 16'h0);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 3'd6, 16'h0E0E, 16'h0);
    cycle();
    check("flush_pre_full", bus.in_ready, 1'b0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'd7, 16'h0F0F, 16'h0);
    cycle();
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_reg_write", bus.out_reg_write, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    check("flush_stays_empty", bus.out_valid, 1'b0);

    // Reset while full
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 3'd3, 16'h1111, 16'h2222);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 3'd2, 16'h3333, 16'h4444);
    cycle();
    check("rst_pre_full", bus.in_ready, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    check_zero_outputs("midrst");
    rst = 1'b0;
    cycle();

    // Entry after reset emerges with normal latency
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd1, 16'h5555, 16'h6666);
    cycle();
    check("post_rst_wb", bus.out_wb_data, 16'h6666);
    check("post_rst_reg_write", bus.out_reg_write, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cycle();

`ifdef MEM_WB_STALL_CNT_EN
    // Saturating stall counter, unaffected by flush
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h0, 16'h0077);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 70000; i++) cycle();
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("stall_cnt_after_flush", stall_cnt, 16'hFFFF);
    cycle();
    check("stall_cnt_hold", stall_cnt, 16'hFFFF);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
Parametrised MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Stalls from the writeback side no longer drop or duplicate instructions.
- Adds synchronous flush (bubble insertion) and a registered writeback-data select (memory data vs ALU result).
- Sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 16, width of memory read data, ALU result and writeback data
REG_ADDR_W, 3, width of destination register index

Ports:
clk  in  1  stage clock; all state updates on the falling edge of clk
rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk
flush  in  1  synchronous pipeline flush; discards all held entries
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  block can accept an entry this cycle
in_reg_write  in  1  instruction writes the register file
in_mem_to_reg  in  1  1 = writeback memory data, 0 = writeback ALU result
in_write_reg  in  REG_ADDR_W  destination register index
in_mem_data  in  DATA_W  data-memory read data
in_alu_result  in  DATA_W  ALU result
out_valid  out  1  output entry valid
out_ready  in  1  WB stage consumes the output entry
out_reg_write  out  1  registered reg_write, forced 0 when out_valid=0
out_mem_to_reg  out  1  registered mem_to_reg
out_write_reg  out  REG_ADDR_W  registered destination index
out_mem_data  out  DATA_W  registered memory data
out_alu_result  out  DATA_W  registered ALU result
out_wb_data  out  DATA_W  registered writeback value (in_mem_to_reg ? in_mem_data : in_alu_result, computed at capture)
stall_cnt  out  16  stall cycle counter; present only with MEM_WB_STALL_CNT_EN

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. Each entry holds reg_write, mem_to_reg, write_reg, mem_data, alu_result and wb_data.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- in_ready and out_valid are pure functions of the state register; there is no combinational path from in_valid or out_ready.
- Transitions, evaluated on each falling edge of clk:
  - EMPTY: accept -> ONE, main<=input; else stay EMPTY.
  - ONE: accept&drain -> ONE, main<=input. accept&!drain -> FULL, skid<=input. !accept&drain -> EMPTY. Otherwise stay ONE and hold.
  - FULL: drain -> ONE, main<=skid; in_valid is ignored. Otherwise stay FULL and hold.
- Priority: rst > flush > handshake.
  - flush forces EMPTY and ignores a simultaneous accept/drain.
  - Payload registers need not clear on flush, but out_reg_write must read 0 while out_valid=0.
- Reset: state=EMPTY and every output is 0, including all payload outputs, out_wb_data, out_valid and stall_cnt. in_ready=1 from the first edge after reset deasserts.
- Reset or flush mid-operation loses held entries without writeback. The next accepted entry emerges with normal latency.
- Latency: 1 clk from accept to out_valid when EMPTY. Sustained throughput is 1 entry per cycle with out_ready held high.
- Ordering: entries emerge strictly in acceptance order. No entry is duplicated or dropped, except on flush or rst.
- Widths: out_wb_data is the exact DATA_W select; no sign or zero extension.

Optional Feature:
MEM_WB_STALL_CNT_EN
- Defined:
  - stall_cnt port exists.
  - 16-bit counter increments on each edge where out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_wb_pkg:
  - State encodings EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
  - Default widths DATA_W=16, REG_ADDR_W=3.
  - Stall counter width 16 and saturation constant.
- One sub-module: pipe_entry_reg.
  - Single payload register with load-enable, parametrised on DATA_W/REG_ADDR_W.
  - Instantiated twice, for main and skid.
  - Computes wb_data at load time.
- Top level holds the FSM, muxes and the optional counter.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, out_valid=0, in_ready=1. After release, accept {reg_write=1, mem_to_reg=1, write_reg=3'd5, mem_data=16'hBEEF, alu=16'h1234} with out_ready=1 -> next edge out_valid=1, out_write_reg=5, out_wb_data=16'hBEEF.
- Streaming: 8 back-to-back entries, alu=16'h0001..16'h0008, mem_to_reg=0, out_ready=1 -> out_wb_data 1..8 on consecutive cycles; in_ready stays 1.
- Stall/skid: out_ready=0 while sending A=16'h00AA and B=16'h00BB -> state FULL, in_ready=0, C held off. Raise out_ready -> outputs AA, BB, CC in order with no loss.
- Flush priority: in FULL, assert flush with in_valid=1 and out_ready=1 -> next edge out_valid=0, out_reg_write=0, in_ready=1; neither held entry nor input appears.
- Reset mid-stall: FULL state, rst=1 -> EMPTY, outputs 0. With MEM_WB_STALL_CNT_EN defined, stall_cnt=0.
- Stall counter (MEM_WB_STALL_CNT_EN): out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds. A flush does not change it.
